alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter IDLE_INSTR, default 32'hF000_0000: instruction word driven to the ALU when no operation issues.
REQ-002 Port clk  input  1  single clock; all state updates on posedge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Ports req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 Ports req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 Ports req0_instr / req1_instr  input  32 each  instruction word (cond [31:28], op [27:24], set-flags [23], imm [18:3], shift class [2:0]).
REQ-007 Ports req0_r1, req0_r2, req1_r1, req1_r2  input  32 each  operands.
REQ-008 Ports alu_R1, alu_R2, alu_instr  output  32 each  registered drive to the shared ALU.
REQ-009 Ports alu_out  input  33; alu_flg  input  4  ALU result and flags.
REQ-010 Port rsp_valid  output  1  response held.
REQ-011 Port rsp_ready  input  1  consumer takes the response.
REQ-012 Port rsp_id  output  1  requester that owns the response.
REQ-013 Port rsp_data  output  33; rsp_flg  output  4  captured result and flags.
REQ-014 Port ops_count  output  16  completed-operation counter.

Function
REQ-015 FSM states: IDLE, ISSUE, CAPTURE, RESP; one state per cycle except IDLE and RESP, which hold.
REQ-016 IDLE: on any reqN_valid, grant one requester, assert its reqN_ready for that single cycle, latch instr/r1/r2 into alu_* registers, latch grant id, go to ISSUE.
REQ-017 Arbitration is round-robin: if both valid, grant the requester not granted last; last-grant pointer resets to 1, so req0 wins the first tie.
REQ-018 Only one reqN_ready is high in any cycle; neither ready is high outside IDLE.
REQ-019 ISSUE: alu_* hold the latched operation; the ALU registers its result at the end of this cycle; go to CAPTURE.
REQ-020 CAPTURE: alu_instr returns to IDLE_INSTR; alu_R1/alu_R2 hold; sample alu_out into rsp_data and alu_flg into rsp_flg; rsp_id = latched grant; go to RESP.
REQ-021 RESP: rsp_valid = 1; rsp_data, rsp_flg, and rsp_id stable until rsp_valid && rsp_ready; on that cycle go to IDLE and increment ops_count.
REQ-022 ops_count wraps from 16'hFFFF to 0.
REQ-023 Issue-to-response latency: grant in cycle T gives rsp_valid in cycle T+3; minimum throughput is 1 op per 4 cycles when rsp_ready is held high.
REQ-024 A failed ALU condition needs no special handling: rsp_data and rsp_flg carry whatever alu_out and alu_flg show in CAPTURE.
REQ-025 A requester that drops reqN_valid without ready is not granted; no side effects.
REQ-026 In every state other than ISSUE, alu_instr = IDLE_INSTR.

Reset
REQ-027 While rst is high and immediately on its assertion:
- state = IDLE
- all ready outputs, rsp_valid, and rsp_id = 0
- rsp_data, rsp_flg, ops_count, alu_R1, and alu_R2 = 0
- alu_instr = IDLE_INSTR
- last-grant pointer = 1
REQ-028 Reset asserted mid-operation (ISSUE, CAPTURE, or RESP) abandons the operation; no response is produced and ops_count is not incremented.

Verification
REQ-029 Single op: req0 with instr 32'hE000_0000 (ADD), r1 = 5, r2 = 7, ALU model returns 12 -> req0_ready in cycle T, rsp_valid in T+3, rsp_data = 12, rsp_id = 0, ops_count = 1.
REQ-030 Tie: req0 and req1 both held valid, rsp_ready = 1 -> grants alternate 0, 1, 0, 1, with a grant every 4 cycles; after 4 ops ops_count = 4.
REQ-031 Backpressure: rsp_ready = 0 for 10 cycles in RESP -> rsp_valid and rsp_data held stable; no reqN_ready asserted; completes on the first rsp_ready cycle.
REQ-032 Reset mid-op: assert rst in CAPTURE -> all outputs take reset values asynchronously; after release, a new req1 op completes normally with rsp_id = 1.
REQ-033 Wrap: preload ops_count to 16'hFFFF via completed ops (or force) -> the next completion gives ops_count = 0.
REQ-034 Idle drive: no valids for 20 cycles -> alu_instr = IDLE_INSTR and no ready asserted throughout.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - two-requester round-robin issue controller for a shared ALU
module alu_issue_ctrl #(
    parameter logic [31:0] IDLE_INSTR = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_instr,
    input  logic [31:0] req0_r1,
    input  logic [31:0] req0_r2,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_instr,
    input  logic [31:0] req1_r1,
    input  logic [31:0] req1_r2,

    output logic [31:0] alu_R1,
    output logic [31:0] alu_R2,
    output logic [31:0] alu_instr,
    input  logic [32:0] alu_out,
    input  logic [3:0]  alu_flg,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [32:0] rsp_data,
    output logic [3:0]  rsp_flg,

    output logic [15:0] ops_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0] state;
    logic       last_grant;
    logic       grant_id;
    logic       grant0;
    logic       grant1;

    // Round-robin pick in IDLE: on a tie the requester not granted last wins.
    // Readies are held low while reset is asserted even though state is IDLE.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == S_IDLE && !rst) begin
            grant0 = req0_valid && (!req1_valid || last_grant);
            grant1 = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == S_RESP);

    // Issue FSM: latch the winner, drive the ALU for one cycle, capture, then hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            alu_R1     <= 32'd0;
            alu_R2     <= 32'd0;
            alu_instr  <= IDLE_INSTR;
            rsp_id     <= 1'b0;
            rsp_data   <= 33'd0;
            rsp_flg    <= 4'd0;
            ops_count  <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        state      <= S_ISSUE;
                        alu_instr  <= grant1 ? req1_instr : req0_instr;
                        alu_R1     <= grant1 ? req1_r1 : req0_r1;
                        alu_R2     <= grant1 ? req1_r2 : req0_r2;
                        grant_id   <= grant1;
                        last_grant <= grant1;
                    end
                end
                S_ISSUE: begin
                    // The ALU registers its result at this edge; operands stay put.
                    state     <= S_CAPTURE;
                    alu_instr <= IDLE_INSTR;
                end
                S_CAPTURE: begin
                    state    <= S_RESP;
                    rsp_data <= alu_out;
                    rsp_flg  <= alu_flg;
                    rsp_id   <= grant_id;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        ops_count <= ops_count + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
